// File: rtl/nibble_serial_sub_if.sv
// Operand/result handshake bundle for nibble_serial_sub.
// When ADDSUB_OP_EN is defined the bundle also carries the add/subtract select 'op'.
interface nibble_serial_sub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
`ifdef ADDSUB_OP_EN
  logic             op;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ovf;

`ifdef ADDSUB_OP_EN
  modport master (output in_valid, a, b, bi, op, out_ready,
                  input  in_ready, out_valid, d, bo, ovf);
  modport slave  (input  in_valid, a, b, bi, op, out_ready,
                  output in_ready, out_valid, d, bo, ovf);
`else
  modport master (output in_valid, a, b, bi, out_ready,
                  input  in_ready, out_valid, d, bo, ovf);
  modport slave  (input  in_valid, a, b, bi, out_ready,
                  output in_ready, out_valid, d, bo, ovf);
`endif
endinterface

// File: rtl/nibble_serial_sub.sv
// Nibble-serial subtractor: d = a - b - bi, one 4-bit lookahead slice per clock, LSB first.
// Optional ADDSUB_OP_EN: captured 'op' selects subtract (1) or add (0).
module nibble_serial_sub #(
  parameter int unsigned WIDTH = 16
) (
  input logic                clk,
  input logic                rst_n,
  nibble_serial_sub_if.slave bus
);
  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic             carry_q;
  logic             bo_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             sub_q;

  logic [CW+1:0]    idx;
  logic [3:0]       xn;
  logic [3:0]       yn;
  logic [3:0]       gn;
  logic [3:0]       pn;
  logic [3:0]       sn;
  logic [4:0]       cv;
  logic             bo_c;
  logic             ovf_c;

`ifndef ADDSUB_OP_EN
  assign sub_q = 1'b1;
`endif

  // Current slice: subtraction is a + ~b with the borrow carried as an inverted carry.
  always_comb begin
    idx   = {cnt, 2'b00};
    xn    = a_q[idx +: 4];
    yn    = sub_q ? ~b_q[idx +: 4] : b_q[idx +: 4];
    gn    = xn & yn;
    pn    = xn ^ yn;
    cv[0] = carry_q;
    cv[1] = gn[0] | (pn[0] & cv[0]);
    cv[2] = gn[1] | (pn[1] & gn[0]) | (pn[1] & pn[0] & cv[0]);
    cv[3] = gn[2] | (pn[2] & gn[1]) | (pn[2] & pn[1] & gn[0])
          | (pn[2] & pn[1] & pn[0] & cv[0]);
    cv[4] = gn[3] | (pn[3] & gn[2]) | (pn[3] & pn[2] & gn[1])
          | (pn[3] & pn[2] & pn[1] & gn[0])
          | (pn[3] & pn[2] & pn[1] & pn[0] & cv[0]);
    sn    = pn ^ cv[3:0];
    bo_c  = sub_q ? ~cv[4] : cv[4];
    ovf_c = (sub_q ? (a_q[WIDTH-1] ^ b_q[WIDTH-1]) : ~(a_q[WIDTH-1] ^ b_q[WIDTH-1]))
          & (sn[3] ^ a_q[WIDTH-1]);
  end

  // Control and datapath state; counter is cleared on accept and holds at N-1 in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      carry_q     <= 1'b0;
      bo_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ADDSUB_OP_EN
      sub_q       <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            cnt   <= '0;
            state <= RUN;
`ifdef ADDSUB_OP_EN
            sub_q   <= bus.op;
            carry_q <= bus.op ? ~bus.bi : bus.bi;
`else
            carry_q <= ~bus.bi;
`endif
          end
        end
        RUN: begin
          d_q[idx +: 4] <= sn;
          carry_q       <= cv[4];
          if (cnt == CW'(N - 1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            bo_q        <= bo_c;
            ovf_q       <= ovf_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) & rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.d         = d_q;
  assign bus.bo        = bo_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub: scoreboard of expected results,
// directed corner cases, backpressure, back-to-back issue, reset abort and a random sweep.
module tb_nibble_serial_sub;
  localparam int unsigned W = 16;
  localparam int unsigned N = W / 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  nibble_serial_sub_if #(.WIDTH(W)) bus ();
  nibble_serial_sub #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bi, input logic op);
    logic [W:0] r;
    exp_t       e;
    if (op) r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    else    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, bi};
    e.d   = r[W-1:0];
    e.bo  = r[W];
    e.ovf = op ? ((a[W-1] ^ b[W-1]) & (e.d[W-1] ^ a[W-1]))
               : (~(a[W-1] ^ b[W-1]) & (e.d[W-1] ^ a[W-1]));
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accept edge, then scramble them to show they are not re-read.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                      input exp_t e);
    bus.a        = a;
    bus.b        = b;
    bus.bi       = bi;
    bus.in_valid = 1'b1;
    sb.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.bi       = 1'($urandom);
  endtask

  task automatic wait_out(output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 4 * N + 10) begin
      tick();
      cyc++;
      seen = bus.out_valid;
    end
  endtask

  task automatic test_reset;
    exp_t got;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.bi        = 1'b0;
`ifdef ADDSUB_OP_EN
    bus.op        = 1'b1;
`endif
    tick();
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
    end
    got = '{d: bus.d, bo: bus.bo, ovf: bus.ovf};
    n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL reset_outputs got %h exp 0", got);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_in_ready got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [5] = '{16'h1234, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF};
    logic [W-1:0] tb [5] = '{16'h0234, 16'h0001, 16'h0000, 16'h0001, 16'hFFFF};
    logic         tbi[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_t         te [5] = '{'{16'h1000, 1'b0, 1'b0}, '{16'hFFFF, 1'b1, 1'b0},
                             '{16'hFFFF, 1'b1, 1'b0}, '{16'h7FFF, 1'b0, 1'b1},
                             '{16'h8000, 1'b1, 1'b1}};
    exp_t got, e;
    int   cyc;
    bit   seen;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(ta[i], tb[i], tbi[i], te[i]);
      wait_out(cyc, seen);
      n_cmp++;
      if (!seen || cyc != N) begin
        n_err++; $display("FAIL directed%0d_latency got %0d (seen %0b) exp %0d", i, cyc, seen, N);
      end
      if (seen && sb.size() > 0) begin
        e   = sb.pop_front();
        got = '{d: bus.d, bo: bus.bo, ovf: bus.ovf};
        n_cmp++;
        if (got !== e) begin
          n_err++; $display("FAIL directed%0d_result got d=%h bo=%b ovf=%b exp d=%h bo=%b ovf=%b",
                            i, got.d, got.bo, got.ovf, e.d, e.bo, e.ovf);
        end
      end else begin
        sb.delete();
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_err++; $display("FAIL directed%0d_idle got out_valid=%b in_ready=%b exp 0/1",
                          i, bus.out_valid, bus.in_ready);
      end
    end
`ifdef ADDSUB_OP_EN
    bus.op = 1'b0;
    send(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0});
    wait_out(cyc, seen);
    n_cmp++;
    if (!seen || cyc != N) begin
      n_err++; $display("FAIL add_latency got %0d exp %0d", cyc, N);
    end
    if (seen && sb.size() > 0) begin
      e   = sb.pop_front();
      got = '{d: bus.d, bo: bus.bo, ovf: bus.ovf};
      n_cmp++;
      if (got !== e) begin
        n_err++; $display("FAIL add_result got %h exp %h", got, e);
      end
    end else begin
      sb.delete();
    end
    tick();
    bus.op = 1'b1;
`endif
  endtask

  task automatic test_backpressure;
    exp_t e, got;
    int   cyc;
    bit   seen;
    e = model(16'h4321, 16'h1234, 1'b1, 1'b1);
    bus.out_ready = 1'b0;
    send(16'h4321, 16'h1234, 1'b1, e);
    wait_out(cyc, seen);
    n_cmp++;
    if (!seen || cyc != N) begin
      n_err++; $display("FAIL bp_latency got %0d exp %0d", cyc, N);
    end
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      tick();
      got = '{d: bus.d, bo: bus.bo, ovf: bus.ovf};
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || got !== e) begin
        n_err++; $display("FAIL bp_hold%0d got ov=%b ir=%b res=%h exp ov=1 ir=0 res=%h",
                          k, bus.out_valid, bus.in_ready, got, e);
      end
    end
    if (sb.size() > 0) void'(sb.pop_front());
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    got = '{d: bus.d, bo: bus.bo, ovf: bus.ovf};
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || got !== e) begin
      n_err++; $display("FAIL bp_release got ov=%b ir=%b res=%h exp ov=0 ir=1 res=%h",
                        bus.out_valid, bus.in_ready, got, e);
    end
  endtask

  task automatic test_back_to_back;
    exp_t         e, got;
    logic [W-1:0] a, b;
    int           cyc;
    bit           seen;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      a = W'($urandom);
      b = W'($urandom);
      bus.a        = a;
      bus.b        = b;
      bus.bi       = 1'b0;
      bus.in_valid = 1'b1;
      sb.push_back(model(a, b, 1'b0, 1'b1));
      wait_out(cyc, seen);
      n_cmp++;
      if (!seen || cyc != N + 1) begin
        n_err++; $display("FAIL b2b%0d_interval got %0d exp %0d", t, cyc, N + 1);
      end
      if (seen && sb.size() > 0) begin
        e   = sb.pop_front();
        got = '{d: bus.d, bo: bus.bo, ovf: bus.ovf};
        n_cmp++;
        if (got !== e) begin
          n_err++; $display("FAIL b2b%0d_result got %h exp %h", t, got, e);
        end
      end else begin
        sb.delete();
      end
      if (t == 2) bus.in_valid = 1'b0;
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b%0d_idle got ov=%b ir=%b exp 0/1", t, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset_abort;
    exp_t e, got;
    int   cyc;
    bit   seen;
    bit   leaked;
    bus.out_ready = 1'b1;
    bus.a         = 16'h5555;
    bus.b         = 16'h1111;
    bus.bi        = 1'b0;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.d !== '0) begin
      n_err++; $display("FAIL abort_reset got ov=%b ir=%b d=%h exp 0/0/0000",
                        bus.out_valid, bus.in_ready, bus.d);
    end
    rst_n = 1'b1;
    #1;
    leaked = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      tick();
      if (bus.out_valid === 1'b1) leaked = 1'b1;
    end
    n_cmp++;
    if (leaked || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_no_output got leaked=%b ir=%b exp 0/1", leaked, bus.in_ready);
    end
    send(16'h0010, 16'h0001, 1'b0, '{16'h000F, 1'b0, 1'b0});
    wait_out(cyc, seen);
    n_cmp++;
    if (!seen || cyc != N) begin
      n_err++; $display("FAIL abort_next_latency got %0d exp %0d", cyc, N);
    end
    if (seen && sb.size() > 0) begin
      e   = sb.pop_front();
      got = '{d: bus.d, bo: bus.bo, ovf: bus.ovf};
      n_cmp++;
      if (got !== e) begin
        n_err++; $display("FAIL abort_next_result got %h exp %h", got, e);
      end
    end else begin
      sb.delete();
    end
    tick();
  endtask

  task automatic test_random;
    exp_t         e, got;
    logic [W-1:0] a, b;
    logic         bi, op;
    int           cyc;
    bit           seen;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0:       a = '0;
        1:       a = {1'b1, {(W-1){1'b0}}};
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       b = '1;
        1:       b = {1'b0, {(W-1){1'b1}}};
        default: b = W'($urandom);
      endcase
      bi = 1'($urandom);
      op = 1'b1;
`ifdef ADDSUB_OP_EN
      op     = 1'($urandom);
      bus.op = op;
`endif
      send(a, b, bi, model(a, b, bi, op));
      wait_out(cyc, seen);
      n_cmp++;
      if (!seen || cyc != N) begin
        n_err++; $display("FAIL rand%0d_latency got %0d exp %0d", t, cyc, N);
      end
      if (seen && sb.size() > 0) begin
        e   = sb.pop_front();
        got = '{d: bus.d, bo: bus.bo, ovf: bus.ovf};
        n_cmp++;
        if (got !== e) begin
          n_err++; $display("FAIL rand%0d_result a=%h b=%h bi=%b op=%b got %h exp %h",
                            t, a, b, bi, op, got, e);
        end
      end else begin
        sb.delete();
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
